// File: rtl/jtag_cmd_bridge_if.sv
// Byte-stream and memory-port signals of the JTAG command bridge.
// The slave modport is the bridge; the master modport is the JTAG host plus memory side.
interface jtag_cmd_bridge_if #(
  parameter int unsigned ADDR_BYTES = 2
);
  logic                    wr_valid;
  logic [7:0]              wr_data;
  logic                    rd_valid;
  logic [7:0]              rd_data;
  logic                    rd_ack;
  logic                    mem_req;
  logic                    mem_we;
  logic [8*ADDR_BYTES-1:0] mem_addr;
  logic [31:0]             mem_wdata;
  logic                    mem_ready;
  logic [31:0]             mem_rdata;

  modport master (
    output wr_valid, wr_data, rd_ack, mem_ready, mem_rdata,
    input  rd_valid, rd_data, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_valid, wr_data, rd_ack, mem_ready, mem_rdata,
    output rd_valid, rd_data, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/jtag_cmd_bridge.sv
// Decodes JTAG command bytes into memory reads/writes, LED loads and status queries,
// and streams read responses back to the host one byte per ack.
module jtag_cmd_bridge #(
  parameter int unsigned ADDR_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  jtag_cmd_bridge_if.slave        bus,
  output logic [7:0]              leds,
  output logic                    err
);
  localparam int unsigned AW = 8 * ADDR_BYTES;

  typedef enum logic [2:0] {StIdle, StAddr, StWdata, StLedb, StMem, StSend} state_e;

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic            is_write_q;
  logic            is_status_q;
  logic [31:0]     rsp_q;
  logic            rd_valid_q;
  logic [7:0]      rd_data_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [AW-1:0]   mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic [7:0]      leds_q;
  logic            err_q;

  logic last_addr;
  logic last_send;

  assign last_addr = (cnt_q == 3'(ADDR_BYTES - 1));
  assign last_send = is_status_q || (cnt_q == 3'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      is_status_q <= 1'b0;
      rsp_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      leds_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.wr_valid) begin
            cnt_q <= '0;
            case (bus.wr_data)
              8'h01, 8'h02: begin
                is_write_q <= (bus.wr_data == 8'h01);
                state_q    <= StAddr;
              end
              8'h03: state_q <= StLedb;
              8'h04: begin
                is_status_q <= 1'b1;
                rd_valid_q  <= 1'b1;
                rd_data_q   <= {7'b0, err_q};
                state_q     <= StSend;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        StAddr: begin
          if (bus.wr_valid) begin
            mem_addr_q <= AW'({mem_addr_q, bus.wr_data});
            cnt_q      <= cnt_q + 3'd1;
            if (last_addr) begin
              cnt_q <= '0;
              if (is_write_q) begin
                state_q <= StWdata;
              end else begin
                mem_req_q <= 1'b1;
                mem_we_q  <= 1'b0;
                state_q   <= StMem;
              end
            end
          end
        end
        StWdata: begin
          if (bus.wr_valid) begin
            mem_wdata_q <= {mem_wdata_q[23:0], bus.wr_data};
            cnt_q       <= cnt_q + 3'd1;
            if (cnt_q == 3'd3) begin
              cnt_q     <= '0;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b1;
              state_q   <= StMem;
            end
          end
        end
        StLedb: begin
          if (bus.wr_valid) begin
            leds_q  <= bus.wr_data;
            state_q <= StIdle;
          end
        end
        StMem: begin
          if (bus.wr_valid) err_q <= 1'b1;
          if (bus.mem_ready) begin
            mem_req_q <= 1'b0;
            cnt_q     <= '0;
            if (mem_we_q) begin
              state_q <= StIdle;
            end else begin
              is_status_q <= 1'b0;
              rsp_q       <= bus.mem_rdata;
              rd_valid_q  <= 1'b1;
              rd_data_q   <= bus.mem_rdata[31:24];
              state_q     <= StSend;
            end
          end
        end
        StSend: begin
          if (bus.rd_ack) begin
            if (last_send) begin
              rd_valid_q  <= 1'b0;
              is_status_q <= 1'b0;
              state_q     <= StIdle;
              if (is_status_q) err_q <= 1'b0;
            end else begin
              // rsp_q[31:24] is already on rd_data; the next byte sits just below it
              rd_data_q <= rsp_q[23:16];
              rsp_q     <= {rsp_q[23:0], 8'h00};
              cnt_q     <= cnt_q + 3'd1;
            end
          end
          // An overrun in the same cycle as the status ack still leaves err set
          if (bus.wr_valid) err_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign leds          = leds_q;
  assign err           = err_q;
endmodule

// File: tb/tb_jtag_cmd_bridge.sv
// Bench for jtag_cmd_bridge: packet-level queue model checked every cycle, plus directed
// literal checks of the documented scenarios.
module tb_jtag_cmd_bridge;
  localparam int unsigned AB = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] leds;
  logic       err;

  jtag_cmd_bridge_if #(.ADDR_BYTES(AB)) bus ();

  jtag_cmd_bridge #(.ADDR_BYTES(AB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .leds  (leds),
    .err   (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: asserts mem_ready once mem_req has been seen for mem_delay cycles.
  int mem_delay = 0;
  int wait_cnt  = 0;
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) begin
      bus.mem_ready = (wait_cnt >= mem_delay);
      wait_cnt++;
    end else begin
      bus.mem_ready = 1'b0;
      wait_cnt      = 0;
    end
  end

  // Packet-level model: bytes collect into a packet, complete packets execute at once,
  // responses sit in a byte queue; the bridge is busy while a request or response is pending.
  logic [7:0]      pkt[$];
  logic [7:0]      resp[$];
  logic            m_req, m_we, m_err, resp_status;
  logic [8*AB-1:0] m_addr;
  logic [31:0]     m_wdata;
  logic [7:0]      m_leds;
  bit              busy;
  int              plen;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt.delete();
      resp.delete();
      m_req = 0; m_we = 0; m_err = 0; resp_status = 0;
      m_addr = '0; m_wdata = '0; m_leds = '0;
    end else begin
      busy = m_req || (resp.size() != 0);
      if (m_req && bus.mem_ready) begin
        m_req = 0;
        if (!m_we) begin
          for (int i = 3; i >= 0; i--) resp.push_back(bus.mem_rdata[8*i +: 8]);
          resp_status = 0;
        end
      end else if (resp.size() != 0 && bus.rd_ack) begin
        void'(resp.pop_front());
        if (resp.size() == 0 && resp_status) m_err = 0;
      end
      if (bus.wr_valid) begin
        if (busy) begin
          m_err = 1;
        end else begin
          pkt.push_back(bus.wr_data);
          case (pkt[0])
            8'h01:   plen = 1 + AB + 4;
            8'h02:   plen = 1 + AB;
            8'h03:   plen = 2;
            8'h04:   plen = 1;
            default: plen = 0;
          endcase
          if (plen == 0) begin
            m_err = 1;
            pkt.delete();
          end else if (pkt.size() == plen) begin
            if (pkt[0] == 8'h01 || pkt[0] == 8'h02) begin
              for (int i = 1; i <= AB; i++) m_addr = {m_addr[8*AB-9:0], pkt[i]};
              if (pkt[0] == 8'h01)
                for (int i = AB + 1; i <= AB + 4; i++) m_wdata = {m_wdata[23:0], pkt[i]};
              m_we  = (pkt[0] == 8'h01);
              m_req = 1;
            end else if (pkt[0] == 8'h03) begin
              m_leds = pkt[1];
            end else begin
              resp.push_back({7'b0, m_err});
              resp_status = 1;
            end
            pkt.delete();
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_valid", 32'(bus.rd_valid), 32'(resp.size() != 0));
      if (resp.size() != 0) check("rd_data", 32'(bus.rd_data), 32'(resp[0]));
      check("mem_req", 32'(bus.mem_req), 32'(m_req));
      if (m_req) begin
        check("mem_we", 32'(bus.mem_we), 32'(m_we));
        check("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
        if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
      end
      check("leds", 32'(leds), 32'(m_leds));
      check("err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.wr_valid = 1'b1;
    bus.wr_data  = b;
    @(negedge clk);
    bus.wr_valid = 1'b0;
  endtask

  task automatic ack();
    bus.rd_ack = 1'b1;
    @(negedge clk);
    bus.rd_ack = 1'b0;
  endtask

  task automatic wait_rd_valid(input string name, input int budget);
    int n = 0;
    while (bus.rd_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.rd_valid !== 1'b1) check(name, 32'(bus.rd_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ack    = 1'b0;
    bus.mem_rdata = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    tick(3);
    chk_en = 1'b1;

    check("rst rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst rd_data", 32'(bus.rd_data), 32'h00);
    check("rst mem_req", 32'(bus.mem_req), 32'd0);
    check("rst mem_we", 32'(bus.mem_we), 32'd0);
    check("rst mem_addr", 32'(bus.mem_addr), 32'h0);
    check("rst mem_wdata", bus.mem_wdata, 32'h0);
    check("rst leds", 32'(leds), 32'h00);
    check("rst err", 32'(err), 32'd0);
    reset = 1'b1;
    tick(2);

    // LED load
    send_byte(8'h03);
    send_byte(8'hA5);
    check("led leds", 32'(leds), 32'hA5);
    check("led no mem_req", 32'(bus.mem_req), 32'd0);
    tick(1);

    // WRITE with 3 wait cycles
    mem_delay = 3;
    send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check("wr mem_addr", 32'(bus.mem_addr), 32'h1234);
    check("wr mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("wr mem_we", 32'(bus.mem_we), 32'd1);
    n = 0;
    while (bus.mem_req === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wr req cycles", 32'(n), 32'd4);
    check("wr no rd_valid", 32'(bus.rd_valid), 32'd0);

    // READ, zero-wait
    mem_delay = 0;
    bus.mem_rdata = 32'hCAFEF00D;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h10);
    check("rd mem_addr", 32'(bus.mem_addr), 32'h0010);
    tick(1);
    check("rd valid", 32'(bus.rd_valid), 32'd1);
    check("rd byte0", 32'(bus.rd_data), 32'hCA);
    tick(2);
    check("rd byte0 held", 32'(bus.rd_data), 32'hCA);
    ack(); check("rd byte1", 32'(bus.rd_data), 32'hFE);
    ack(); check("rd byte2", 32'(bus.rd_data), 32'hF0);
    ack(); check("rd byte3", 32'(bus.rd_data), 32'h0D);
    ack(); check("rd done", 32'(bus.rd_valid), 32'd0);

    // Overrun during SEND, then STATUS
    bus.mem_rdata = 32'h11223344;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h20);
    wait_rd_valid("ovr rd_valid", 10);
    send_byte(8'h55);
    check("ovr err", 32'(err), 32'd1);
    check("ovr byte0", 32'(bus.rd_data), 32'h11);
    ack(); check("ovr byte1", 32'(bus.rd_data), 32'h22);
    ack(); check("ovr byte2", 32'(bus.rd_data), 32'h33);
    ack(); check("ovr byte3", 32'(bus.rd_data), 32'h44);
    ack(); check("ovr done", 32'(bus.rd_valid), 32'd0);
    send_byte(8'h04);
    check("stat valid", 32'(bus.rd_valid), 32'd1);
    check("stat byte", 32'(bus.rd_data), 32'h01);
    ack();
    check("stat err clr", 32'(err), 32'd0);
    check("stat done", 32'(bus.rd_valid), 32'd0);
    send_byte(8'h04);
    check("stat2 byte", 32'(bus.rd_data), 32'h00);
    ack();

    // Bad opcode
    send_byte(8'h7F);
    check("bad err", 32'(err), 32'd1);
    send_byte(8'h03); send_byte(8'h0F);
    check("bad leds", 32'(leds), 32'h0F);

    // Reset during an outstanding READ
    mem_delay = 100;
    send_byte(8'h02); send_byte(8'hAB); send_byte(8'hCD);
    check("rstmid mem_req", 32'(bus.mem_req), 32'd1);
    check("rstmid mem_addr", 32'(bus.mem_addr), 32'hABCD);
    #2 reset = 1'b0;
    #1;
    check("rstmid req drop", 32'(bus.mem_req), 32'd0);
    check("rstmid rd_valid", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    mem_delay = 1;
    bus.mem_rdata = 32'h0BADC0DE;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h05);
    check("post mem_addr", 32'(bus.mem_addr), 32'h0005);
    wait_rd_valid("post rd_valid", 10);
    check("post byte0", 32'(bus.rd_data), 32'h0B);
    ack(); check("post byte1", 32'(bus.rd_data), 32'hAD);
    ack(); check("post byte2", 32'(bus.rd_data), 32'hC0);
    ack(); check("post byte3", 32'(bus.rd_data), 32'hDE);
    ack(); check("post done", 32'(bus.rd_valid), 32'd0);
    tick(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/jtag_cmd_bridge.md
# jtag_cmd_bridge

Command decoder that sits directly downstream of the virtual-JTAG byte interface. It consumes the byte stream the interface delivers after each JTAG update, assembles it into command packets, and executes them against a single word-wide memory/debug port and an 8-bit LED register. Read results go back to the JTAG interface as a byte-wide valid/ack stream that replaces the interface's constant read tie-offs.

## Interface
Parameters:
- ADDR_BYTES, 2, address bytes per packet; mem_addr width is 8*ADDR_BYTES.

Ports:
- clk  in  1  sole clock (same domain as the JTAG interface)
- reset  in  1  asynchronous, active-low reset
- wr_valid  in  1  one-cycle strobe: wr_data holds a new byte from the JTAG interface
- wr_data  in  8  command byte
- rd_valid  out  1  rd_data holds a byte for the host
- rd_data  out  8  response byte
- rd_ack  in  1  host consumed rd_data (one-cycle pulse)
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  1 = write, 0 = read; valid with mem_req
- mem_addr  out  8*ADDR_BYTES  word address
- mem_wdata  out  32  write data
- mem_ready  in  1  request accepted / read data valid this cycle
- mem_rdata  in  32  read data, sampled when mem_ready=1
- leds  out  8  LED register
- err  out  1  sticky error flag

## Operation
- Packets, first byte is the opcode, multi-byte fields MSB first:
  - 0x01 WRITE: opcode, ADDR_BYTES address, 4 data bytes.
  - 0x02 READ: opcode, ADDR_BYTES address; response is 4 bytes, MSB first.
  - 0x03 LED: opcode, 1 byte loaded into leds.
  - 0x04 STATUS: opcode only; response is 1 byte {7'b0, err}, and err clears when the byte is acked.
  - Any other opcode: ignored, stays in IDLE, err set.
- States: IDLE, ADDR, WDATA, LEDB, MEM, SEND.
  - IDLE --0x01/0x02--> ADDR.
  - IDLE --0x03--> LEDB.
  - IDLE --0x04--> SEND (1 byte).
  - ADDR --last address byte--> WDATA (write) or MEM (read).
  - WDATA --4th byte--> MEM.
  - LEDB --byte--> IDLE.
  - MEM --mem_ready, write--> IDLE.
  - MEM --mem_ready, read--> SEND (4 bytes).
  - SEND --last ack--> IDLE.
- A 3-bit byte counter tracks position within ADDR, WDATA and SEND. The counter resets on every state entry.
- wr_valid in MEM or SEND: the byte is dropped and err is set. The current operation is unaffected.
- rd_ack while rd_valid=0 is ignored.
- Reset values:
  - state IDLE.
  - rd_valid=0, rd_data=0x00.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - leds=0x00.
  - err=0.
- Reset mid-packet or mid-request aborts immediately. A partial packet is discarded, and mem_req drops asynchronously.

## Timing
- All outputs are registered.
- mem_req rises the cycle after the final packet byte is sampled.
- mem_addr, mem_we and mem_wdata are stable for the whole time mem_req is high.
- mem_ready may be high in the first mem_req cycle (zero-wait memory).
- mem_req falls the cycle after mem_ready is sampled high.
- READ: mem_rdata is captured on the mem_ready edge. The next cycle has rd_valid=1 and rd_data=mem_rdata[31:24].
- Each rd_ack with rd_valid=1 presents the next byte on the following cycle. rd_valid stays high between bytes.
- After the final ack, rd_valid=0 on the next cycle and state returns to IDLE.
- STATUS: rd_valid rises the cycle after the opcode is sampled.
- LED: leds updates the cycle after the data byte is sampled.
- Minimum packet throughput is one byte per cycle; back-to-back wr_valid is accepted in every non-MEM/SEND state.
- No timeout: MEM waits indefinitely for mem_ready.

## Test plan
- Reset check. After reset, verify all outputs at their reset values. Then send bytes 0x03, 0xA5: leds=0xA5 one cycle after the second byte; no mem_req.
- WRITE. Send 0x01, 0x12, 0x34, 0xDE, 0xAD, 0xBE, 0xEF with mem_ready delayed 3 cycles:
  - mem_req=1, mem_we=1, mem_addr=0x1234, mem_wdata=0xDEADBEEF, held 4 cycles.
  - Returns to IDLE; no rd_valid.
- READ. Send 0x02, 0x00, 0x10 with zero-wait mem_ready and mem_rdata=0xCAFEF00D:
  - Four acks yield 0xCA, 0xFE, 0xF0, 0x0D.
  - rd_valid falls after the 4th ack.
  - Delaying an ack holds the current byte.
- Overrun and status.
  - Send a byte during SEND of a READ: err=1 and the response is still intact.
  - Then send 0x04: the response byte is 0x01; after its ack, err=0.
  - Send 0x04 again: the response is 0x00.
- Bad opcode. Send 0x7F: err=1, state stays IDLE. A following 0x03, 0x0F still sets leds=0x0F.
- Reset mid-operation. Assert reset while mem_req=1 on a READ: mem_req drops immediately and rd_valid=0. After release, a new READ completes normally.
